game_fsm: RTL and testbench
===========================

GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter WIN_SCORE, default 9: points needed to win a match (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60: frames the ball is held before each serve (1..255).
REQ-003 Parameter HITS_PER_LEVEL, default 4: paddle hits per speed-level increment (1..15).
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 btn_start  input  1  debounced start button level.
REQ-008 hit  input  1  one-cycle pulse: ball struck a paddle.
REQ-009 miss_left  input  1  one-cycle pulse: ball passed the left paddle.
REQ-010 miss_right  input  1  one-cycle pulse: ball passed the right paddle.
REQ-011 state  output  3  current FSM state code.
REQ-012 ball_run  output  1  ball motion enable.
REQ-013 ball_reset  output  1  one-cycle pulse: re-centre the ball.
REQ-014 serve_dir  output  1  serve direction: 0 = toward left, 1 = toward right.
REQ-015 score1  output  4  left player score.
REQ-016 score2  output  4  right player score.
REQ-017 speed  output  3  ball speed level, 0..7.
REQ-018 winner  output  2  00 = none, 01 = left, 10 = right.

Function
REQ-019 States SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-020 start_evt SHALL be the registered rising edge of btn_start; a level held across reset SHALL NOT produce start_evt.
REQ-021 IDLE: ball_run=0; start_evt SHALL clear scores, speed and winner, set serve_dir=0, and move to SERVE.
REQ-022 Every entry into SERVE SHALL assert ball_reset for exactly the first cycle in SERVE and load frame_cnt=SERVE_FRAMES.
REQ-023 SERVE: ball_run=0; each frame_tick SHALL decrement frame_cnt; the tick that makes it 0 SHALL move to PLAY on the next cycle.
REQ-024 PLAY: ball_run=1; each hit SHALL increment hit_cnt.
REQ-025 When hit_cnt reaches HITS_PER_LEVEL, hit_cnt SHALL clear and speed SHALL increment, saturating at 7.
REQ-026 PLAY, miss_right alone: score1+1, serve_dir=1, go to POINT.
REQ-027 PLAY, miss_left alone: score2+1, serve_dir=0, go to POINT.
REQ-028 PLAY, miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT.
REQ-029 A hit in the same cycle as a miss SHALL be ignored.
REQ-030 POINT SHALL last one cycle: ball_run=0, speed and hit_cnt cleared.
REQ-031 From POINT, if a score equals WIN_SCORE, go to OVER; otherwise go to SERVE.
REQ-032 OVER: ball_run=0; winner SHALL be held; scores SHALL be frozen; start_evt SHALL go to IDLE.
REQ-033 Scores SHALL never exceed WIN_SCORE.
REQ-034 hit, miss_left and miss_right SHALL be ignored outside PLAY.
REQ-035 frame_tick SHALL be ignored outside SERVE.
REQ-036 All outputs SHALL be registered; the state change is visible one cycle after the causing input.

Reset
REQ-037 reset SHALL immediately force state=IDLE, ball_run=0, ball_reset=0, serve_dir=0, score1=0, score2=0, speed=0, winner=00, hit_cnt=0, frame_cnt=0 and the edge-detect register=1.
REQ-038 Reset asserted mid-PLAY or mid-SERVE SHALL abandon the match with no residual pulse after release.

Structure
REQ-039 State codes, the winner encoding and the speed maximum (7) SHALL live in the shared package pong_pkg.
REQ-040 Start-edge detection SHALL be a sub-module rise_detect (clk, reset, in, pulse), reusable for other buttons.
REQ-041 The implementation SHALL be a single FSM with separate counter registers, 120-400 lines of RTL.

Verification
REQ-042 Reset, pulse btn_start -> state=SERVE, one ball_reset pulse, and after 60 frame_ticks state=PLAY with ball_run=1.
REQ-043 PLAY, 4 hit pulses -> speed=1; 32 hits -> speed=7, saturated.
REQ-044 PLAY, miss_right -> score1=1, serve_dir=1, POINT for one cycle, then SERVE with ball_reset, speed=0.
REQ-045 PLAY, simultaneous miss_left+miss_right -> scores unchanged, returns to SERVE.
REQ-046 score2=8 with WIN_SCORE=9, miss_left -> score2=9, state=OVER, winner=10; further misses have no effect; start_evt -> IDLE.
REQ-047 Assert reset mid-PLAY with btn_start held high -> all outputs reset immediately; no start_evt after release until btn_start falls and rises again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game logic: FSM state codes, winner encoding
// and speed limits used by game_fsm and any display/ball logic.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic [2:0] SPEED_MAX = 3'd7;

    function automatic logic [2:0] speed_inc(input logic [2:0] cur);
        return (cur == SPEED_MAX) ? SPEED_MAX : cur + 3'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level input. The history register
// resets to 1 so a level already high across reset never yields a pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            prev  <= in;
            pulse <= in & ~prev;
        end
    end

endmodule

// File: rtl/game_fsm.sv
// Pong match controller: serve countdown, rally speed-up, scoring and game over.
// Every output is a flop updated by the single state machine below.
module game_fsm
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 9,
    parameter int SERVE_FRAMES   = 60,
    parameter int HITS_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       hit,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] speed,
    output logic [1:0] winner
);

    localparam logic [3:0] WIN_LVL = 4'(WIN_SCORE);
    localparam logic [7:0] FRAMES  = 8'(SERVE_FRAMES);
    localparam logic [3:0] HITS    = 4'(HITS_PER_LEVEL);

    state_t     cur;
    logic [7:0] frame_cnt;
    logic [3:0] hit_cnt;
    logic       start_evt;

    rise_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .in    (btn_start),
        .pulse (start_evt)
    );

    assign state = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= ST_IDLE;
            ball_run   <= 1'b0;
            ball_reset <= 1'b0;
            serve_dir  <= 1'b0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            speed      <= 3'd0;
            winner     <= WIN_NONE;
            hit_cnt    <= 4'd0;
            frame_cnt  <= 8'd0;
        end else begin
            ball_reset <= 1'b0;
            case (cur)
                ST_IDLE: begin
                    ball_run <= 1'b0;
                    if (start_evt) begin
                        score1     <= 4'd0;
                        score2     <= 4'd0;
                        speed      <= 3'd0;
                        winner     <= WIN_NONE;
                        serve_dir  <= 1'b0;
                        hit_cnt    <= 4'd0;
                        cur        <= ST_SERVE;
                        ball_reset <= 1'b1;
                        frame_cnt  <= FRAMES;
                    end
                end
                ST_SERVE: begin
                    ball_run <= 1'b0;
                    if (frame_tick) begin
                        if (frame_cnt <= 8'd1) begin
                            frame_cnt <= 8'd0;
                            cur       <= ST_PLAY;
                            ball_run  <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    ball_run <= 1'b1;
                    // Any miss ends the rally; a simultaneous hit is discarded.
                    if (miss_left || miss_right) begin
                        cur      <= ST_POINT;
                        ball_run <= 1'b0;
                        speed    <= 3'd0;
                        hit_cnt  <= 4'd0;
                        if (miss_right && !miss_left) begin
                            if (score1 < WIN_LVL) score1 <= score1 + 4'd1;
                            serve_dir <= 1'b1;
                        end else if (miss_left && !miss_right) begin
                            if (score2 < WIN_LVL) score2 <= score2 + 4'd1;
                            serve_dir <= 1'b0;
                        end
                    end else if (hit) begin
                        if (hit_cnt + 4'd1 >= HITS) begin
                            hit_cnt <= 4'd0;
                            speed   <= speed_inc(speed);
                        end else begin
                            hit_cnt <= hit_cnt + 4'd1;
                        end
                    end
                end
                ST_POINT: begin
                    ball_run <= 1'b0;
                    speed    <= 3'd0;
                    hit_cnt  <= 4'd0;
                    if (score1 == WIN_LVL || score2 == WIN_LVL) begin
                        cur    <= ST_OVER;
                        winner <= (score1 == WIN_LVL) ? WIN_LEFT : WIN_RIGHT;
                    end else begin
                        cur        <= ST_SERVE;
                        ball_reset <= 1'b1;
                        frame_cnt  <= FRAMES;
                    end
                end
                ST_OVER: begin
                    ball_run <= 1'b0;
                    if (start_evt) cur <= ST_IDLE;
                end
                default: begin
                    cur      <= ST_IDLE;
                    ball_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: start, serve countdown, speed-up, scoring,
// game over and reset-with-button-held behaviour.
module tb_game_fsm;

    localparam int SF = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       hit = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic [2:0] state;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] speed;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;

    game_fsm #(.WIN_SCORE(9), .SERVE_FRAMES(SF), .HITS_PER_LEVEL(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .hit        (hit),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .state      (state),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .speed      (speed),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then drops the single-cycle pulses; btn_start is a level.
    task automatic applyStimulus(input logic ft, input logic bs, input logic h,
                                 input logic ml, input logic mr);
        frame_tick = ft;
        btn_start  = bs;
        hit        = h;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit        = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, btn_start, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic serveToPlay();
        for (int i = 0; i < SF - 1; i++) applyStimulus(1'b1, btn_start, 1'b0, 1'b0, 1'b0);
        checkOutput("serve_hold", state, 1);
        applyStimulus(1'b1, btn_start, 1'b0, 1'b0, 1'b0);
        checkOutput("serve_to_play", state, 2);
        checkOutput("play_ball_run", ball_run, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_ball_run", ball_run, 0);
        checkOutput("rst_ball_reset", ball_reset, 0);
        checkOutput("rst_serve_dir", serve_dir, 0);
        checkOutput("rst_score1", score1, 0);
        checkOutput("rst_score2", score2, 0);
        checkOutput("rst_speed", speed, 0);
        checkOutput("rst_winner", winner, 0);
        reset = 1'b0;
        idleCycle();
        idleCycle();
        checkOutput("idle_no_start", state, 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_latency", state, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_serve", state, 1);
        checkOutput("serve_ball_reset", ball_reset, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ball_reset_once", ball_reset, 0);
        checkOutput("serve_ball_run", ball_run, 0);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("hit_outside_play", speed, 0);
        serveToPlay();

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("speed_after3", speed, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("speed_after4", speed, 1);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("speed_after28", speed, 7);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("speed_sat32", speed, 7);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_point", state, 3);
        checkOutput("mr_score1", score1, 1);
        checkOutput("mr_score2", score2, 0);
        checkOutput("mr_serve_dir", serve_dir, 1);
        checkOutput("point_speed", speed, 0);
        checkOutput("point_ball_run", ball_run, 0);
        idleCycle();
        checkOutput("point_to_serve", state, 1);
        checkOutput("reserve_ball_reset", ball_reset, 1);

        serveToPlay();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("both_point", state, 3);
        checkOutput("both_score1", score1, 1);
        checkOutput("both_score2", score2, 0);
        checkOutput("both_serve_dir", serve_dir, 1);
        idleCycle();
        checkOutput("both_to_serve", state, 1);

        for (int k = 0; k < 8; k++) begin
            serveToPlay();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("ml_point", state, 3);
            idleCycle();
        end
        checkOutput("score2_eight", score2, 8);
        checkOutput("ml_serve_dir", serve_dir, 0);
        checkOutput("eight_serve", state, 1);

        serveToPlay();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("win_score2", score2, 9);
        idleCycle();
        checkOutput("over_state", state, 4);
        checkOutput("over_winner", winner, 2);
        checkOutput("over_ball_run", ball_run, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("over_frozen1", score1, 1);
        checkOutput("over_frozen2", score2, 9);
        checkOutput("over_stays", state, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("over_latency", state, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("over_to_idle", state, 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_serve", state, 1);
        checkOutput("restart_score2", score2, 0);
        checkOutput("restart_winner", winner, 0);
        btn_start = 1'b0;

        serveToPlay();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycle();
        serveToPlay();
        checkOutput("pre_rst_score1", score1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_ignored_play", state, 2);

        reset = 1'b1;
        #1;
        checkOutput("async_rst_state", state, 0);
        checkOutput("async_rst_ball_run", ball_run, 0);
        checkOutput("async_rst_score1", score1, 0);
        checkOutput("async_rst_serve_dir", serve_dir, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) idleCycle();
        checkOutput("held_btn_no_start", state, 0);
        checkOutput("held_btn_no_pulse", ball_reset, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("new_edge_start", state, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
